// File: rtl/uart_pkg.sv
// Shared definitions for the UART pair: FSM state encodings and the baud divisor,
// so transmitter and receiver always derive the same bit period.
package uart_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    function automatic int bit_ticks(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..limit-1, wraps, and flags the last count as the sample tick.
module uart_baud_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tick
);

    logic [W-1:0] count;

    assign tick = (count == limit - W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, LSB-first deserialiser.
// state   | meaning
// S_IDLE  | line idle, waiting for a low level
// S_START | half a bit into the start bit, confirming it is still low
// S_DATA  | sampling data bits at mid-bit
// S_STOP  | sampling the stop bit
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int BAUDRATE        = 115_200,
    parameter int DATA_BIT_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       rx_i,
    output logic [DATA_BIT_LENGTH-1:0] dout_o,
    output logic                       rx_done_tick_o,
    output logic                       frame_err_o,
    output logic                       rx_busy_o
);

    localparam int BIT_TICKS  = bit_ticks(CLK_FREQ, BAUDRATE);
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int TICK_W     = $clog2(BIT_TICKS + 1);
    localparam int BIT_W      = $clog2(DATA_BIT_LENGTH + 1);

    localparam logic [TICK_W-1:0] BIT_LIM  = TICK_W'(BIT_TICKS);
    localparam logic [TICK_W-1:0] HALF_LIM = TICK_W'(HALF_TICKS);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BIT_LENGTH - 1);

    logic [2:0]                 state, state_next;
    logic                       rx_meta, rx_s;
    logic                       tick;
    logic [TICK_W-1:0]          limit;
    logic [BIT_W-1:0]           bit_cnt;
    logic [DATA_BIT_LENGTH-1:0] shreg;
    logic                       shift_en, bit_clr, done_set, err_set;

    // Flops reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign limit = (state == S_START) ? HALF_LIM : BIT_LIM;

    uart_baud_cnt #(
        .W(TICK_W)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst_i),
        .clr  (state_next != state),
        .limit(limit),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (tick) state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && bit_cnt == LAST_BIT) state_next = S_STOP;
            end
            S_STOP: begin
                if (tick) state_next = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = (state == S_DATA) && tick;
        bit_clr   = (state == S_START);
        done_set  = (state == S_STOP) && tick && rx_s;
        err_set   = (state == S_STOP) && tick && !rx_s;
        rx_busy_o = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt        <= '0;
            shreg          <= '0;
            dout_o         <= '0;
            rx_done_tick_o <= 1'b0;
            frame_err_o    <= 1'b0;
        end else begin
            rx_done_tick_o <= done_set;
            frame_err_o    <= err_set;
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[DATA_BIT_LENGTH-1:1]};
            end
            if (done_set) begin
                dout_o <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random loopback checks for uart_rx against a behavioural serial-line model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUDRATE = 100_000;
    localparam int BIT      = CLK_FREQ / BAUDRATE;
    localparam int HALF     = BIT / 2;
    localparam int NBITS    = 8;
    localparam int LATENCY  = 2 + HALF + (NBITS + 1) * BIT + 1;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] dout_o;
    logic       rx_done_tick_o, frame_err_o, rx_busy_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int last_done_cyc = 0;
    logic [7:0] rx_q[$];

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUDRATE(BAUDRATE),
        .DATA_BIT_LENGTH(NBITS)
    ) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .rx_i          (rx_i),
        .dout_o        (dout_o),
        .rx_done_tick_o(rx_done_tick_o),
        .frame_err_o   (frame_err_o),
        .rx_busy_o     (rx_busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (rx_done_tick_o) begin
                done_cnt++;
                last_done_cyc = cyc;
                rx_q.push_back(dout_o);
            end
            if (frame_err_o) err_cnt++;
            if (rx_done_tick_o && frame_err_o) both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v);
        line(1'b0, BIT);
        for (int i = 0; i < NBITS; i++) line(b[i], BIT);
        line(stop_v, BIT);
        rx_i = 1'b1;
    endtask

    initial begin
        int d0, e0, c0, base, gap;
        logic [7:0] exp_q[$];
        logic [7:0] b;

        // reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 32'(dout_o), 32'h0);
        chk("rst_done", 32'(rx_done_tick_o), 32'h0);
        chk("rst_err", 32'(frame_err_o), 32'h0);
        chk("rst_busy", 32'(rx_busy_o), 32'h0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        line(1'b1, 10);

        // 1: single frame 0x53 with latency
        d0 = done_cnt; e0 = err_cnt; c0 = cyc;
        send(8'h53, 1'b1);
        line(1'b1, 5);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_dout", 32'(dout_o), 32'h53);
        chk("t1_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("t1_latency", 32'(last_done_cyc - c0), 32'(LATENCY));

        // 2: back-to-back 0x00, 0xFF
        d0 = done_cnt;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        line(1'b1, 5);
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd2);
        chk("t2_first", 32'(rx_q[rx_q.size()-2]), 32'h00);
        chk("t2_second", 32'(rx_q[rx_q.size()-1]), 32'hFF);

        // 3: 3-cycle glitch rejected
        d0 = done_cnt; e0 = err_cnt;
        line(1'b0, 3);
        line(1'b1, 2 * BIT);
        @(negedge clk);
        chk("t3_busy", 32'(rx_busy_o), 32'h0);
        chk("t3_pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
        chk("t3_dout", 32'(dout_o), 32'hFF);
        @(posedge clk); #1;

        // 4: bad stop bit
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5, 1'b0);
        line(1'b1, 20);
        chk("t4_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd0);
        chk("t4_dout", 32'(dout_o), 32'hFF);

        // 5: long break then 0x3C
        d0 = done_cnt; e0 = err_cnt;
        line(1'b0, 30 * BIT);
        line(1'b1, 20);
        send(8'h3C, 1'b1);
        line(1'b1, 5);
        chk("t5_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t5_dout", 32'(dout_o), 32'h3C);

        // 6: reset during data bit 4, then 0x81
        b = 8'hF0;
        line(1'b0, BIT);
        for (int i = 0; i < 4; i++) line(b[i], BIT);
        rx_i = b[4];
        repeat (HALF) @(posedge clk);
        @(negedge clk);
        chk("t6_busy_mid", 32'(rx_busy_o), 32'h1);
        rst_i = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_rst_dout", 32'(dout_o), 32'h0);
        chk("t6_rst_busy", 32'(rx_busy_o), 32'h0);
        chk("t6_rst_pulses", 32'({rx_done_tick_o, frame_err_o}), 32'h0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        line(1'b1, 20);
        d0 = done_cnt; e0 = err_cnt;
        send(8'h81, 1'b1);
        line(1'b1, 5);
        chk("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t6_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("t6_dout", 32'(dout_o), 32'h81);

        // loopback: 256 random bytes with random idle gaps
        base = rx_q.size();
        e0 = err_cnt;
        for (int k = 0; k < 256; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send(b, 1'b1);
            gap = $urandom_range(0, 3);
            if (gap != 0) line(1'b1, gap * 3);
        end
        line(1'b1, 20);
        chk("lb_count", 32'(rx_q.size() - base), 32'd256);
        for (int k = 0; k < 256; k++) begin
            if (base + k < rx_q.size())
                chk($sformatf("lb_byte%0d", k), 32'(rx_q[base + k]), 32'(exp_q[k]));
            else
                chk($sformatf("lb_byte%0d", k), 32'hFFFF_FFFF, 32'(exp_q[k]));
        end
        chk("lb_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("both_pulses", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
